// File: rtl/sr_pkg.sv
// sr_pkg -- shared definitions for the serial shift-register path.
//   sr_state_e : serializer FSM state encoding (IDLE / SHIFT / LATCH)
//   SR_DATA_W  : default word width, also the depth of the shift register
//   SR_DIV     : default system cycles per serial bit period
package sr_pkg;

    localparam int SR_DATA_W = 8;
    localparam int SR_DIV    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } sr_state_e;

endpackage

// File: rtl/sr_serializer_if.sv
// sr_serializer_if -- parallel-word load handshake into the serializer.
//   load_data  : word to serialize (driven by master)
//   load_valid : load_data is valid this cycle (driven by master)
//   in_ready   : serializer can accept a word (driven by slave)
// A transfer happens on a clk_sr edge where load_valid && in_ready.
interface sr_serializer_if
    import sr_pkg::*;
#(
    parameter int DATA_W = SR_DATA_W
) ();

    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              in_ready;

    modport master (
        output load_data,
        output load_valid,
        input  in_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output in_ready
    );

endinterface

// File: rtl/sr_bit_timer.sv
// sr_bit_timer -- bit-period divider for serial stages.
//   clk_sr : clock, rising edge
//   rst    : asynchronous active-low reset
//   en     : count while high
//   clr    : synchronous clear to zero, overrides en
//   tick   : combinational, high in the last cycle of each DIV-cycle period
module sr_bit_timer
    import sr_pkg::*;
#(
    parameter int DIV = SR_DIV
) (
    input  logic clk_sr,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_sr or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sr_serializer.sv
// sr_serializer -- feeds the serial shift register from a parallel word.
// Captures a word over the ld handshake, shifts it out MSB-first with one
// sr_shift pulse per bit (every DIV cycles), then strobes sr_latch once.
//   clk_sr   : sole clock, rising edge
//   rst      : asynchronous active-low reset
//   ld       : load handshake (slave side): load_data, load_valid, in_ready
//   sr_data  : serial bit to the shift register's data_in
//   sr_shift : one-cycle shift enable, once per bit
//   sr_latch : one-cycle strobe after the final shift
//   busy     : a word is in flight
// Optional build macro SR_PARITY_EN: appends an even-parity bit period
// after the data bits.
//
// state | meaning
// IDLE  | in_ready high, waiting for load_valid
// SHIFT | presenting bits, pulsing sr_shift at the end of each period
// LATCH | single-cycle sr_latch strobe, then back to IDLE
module sr_serializer
    import sr_pkg::*;
#(
    parameter int DATA_W = SR_DATA_W,
    parameter int DIV    = SR_DIV
) (
    input  logic              clk_sr,
    input  logic              rst,
    sr_serializer_if.slave    ld,
    output logic              sr_data,
    output logic              sr_shift,
    output logic              sr_latch,
    output logic              busy
);

`ifdef SR_PARITY_EN
    localparam int N_BITS = DATA_W + 1;
`else
    localparam int N_BITS = DATA_W;
`endif
    localparam int                BIT_W    = $clog2(N_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS);

    sr_state_e         state_q;
    sr_state_e         state_d;
    logic [N_BITS-1:0] shreg_q;
    logic [N_BITS-1:0] word_ext;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              in_ready_q;
    logic              tick;
    logic              accept;
    logic              last_pulse;
    logic              in_ready_d;
    logic              busy_d;
    logic              sr_data_d;
    logic              sr_shift_d;
    logic              sr_latch_d;

`ifdef SR_PARITY_EN
    assign word_ext = {ld.load_data, ^ld.load_data};
`else
    assign word_ext = ld.load_data;
`endif

    assign ld.in_ready = in_ready_q;
    assign accept      = (state_q == IDLE) && ld.load_valid && in_ready_q;
    // bit_cnt_q counts pulses already issued, so the final pulse is the
    // one seen while the count equals the word length.
    assign last_pulse  = sr_shift && (bit_cnt_q == BIT_LAST);

    // The period counter restarts on every entry to SHIFT, so cycle 0 of a
    // word is always the start of the first bit period.
    sr_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk_sr (clk_sr),
        .rst    (rst),
        .en     (state_q == SHIFT),
        .clr    (state_q != SHIFT),
        .tick   (tick)
    );

    // State register and registered outputs.
    always_ff @(posedge clk_sr or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            sr_data    <= 1'b0;
            sr_shift   <= 1'b0;
            sr_latch   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy       <= busy_d;
            sr_data    <= sr_data_d;
            sr_shift   <= sr_shift_d;
            sr_latch   <= sr_latch_d;
        end
    end

    // Datapath: captured word and pulse count.
    always_ff @(posedge clk_sr or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (accept) begin
                shreg_q <= word_ext;
            end else if (state_q == SHIFT && sr_shift) begin
                shreg_q <= shreg_q << 1;
            end

            if (accept) begin
                bit_cnt_q <= '0;
            end else if (tick) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_pulse) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        sr_latch_d = (state_d == LATCH);
        sr_shift_d = tick && (state_d == SHIFT);
        sr_data_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                sr_data_d = accept ? word_ext[N_BITS-1] : 1'b0;
            end
            SHIFT: begin
                // Advance on the edge right after each pulse; the next bit
                // is still one below the MSB of the not-yet-shifted word.
                if (last_pulse) begin
                    sr_data_d = 1'b0;
                end else if (sr_shift) begin
                    sr_data_d = shreg_q[N_BITS-2];
                end else begin
                    sr_data_d = sr_data;
                end
            end
            default: sr_data_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sr_serializer.sv
// tb_sr_serializer -- directed, table-driven bench for sr_serializer
// (DATA_W = 8, DIV = 4) feeding a model of the 8-stage shift register.
// Cycle 0 is the interval right after the accepting edge.
module tb_sr_serializer;
    import sr_pkg::*;

    localparam int DIV = 4;

`ifdef SR_PARITY_EN
    localparam int EXP_PULSES = 9;
    localparam int EXP_LATCH  = 37;
    localparam int EXP_READY  = 38;
`else
    localparam int EXP_PULSES = 8;
    localparam int EXP_LATCH  = 33;
    localparam int EXP_READY  = 34;
`endif

    typedef struct {
        logic [7:0]  word;
        logic [7:0]  reg_val;
        logic [15:0] stream;
    } vec_t;

    logic clk_sr = 1'b0;
    logic rst    = 1'b0;
    logic sr_data;
    logic sr_shift;
    logic sr_latch;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    sr_serializer_if #(.DATA_W(8)) ld_if ();

    sr_serializer #(
        .DATA_W (8),
        .DIV    (DIV)
    ) dut (
        .clk_sr   (clk_sr),
        .rst      (rst),
        .ld       (ld_if),
        .sr_data  (sr_data),
        .sr_shift (sr_shift),
        .sr_latch (sr_latch),
        .busy     (busy)
    );

    always #5 clk_sr = ~clk_sr;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got no summary, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the word is accepted on the following posedge.
    task automatic drive_word(input logic [7:0] w);
        check($sformatf("w%02h ready_before_load", w), int'(ld_if.in_ready), 1);
        ld_if.load_data  = w;
        ld_if.load_valid = 1'b1;
    endtask

    // Follows one word from its accepting edge until in_ready returns.
    // Returns at the negedge where in_ready is first seen high again.
    task automatic observe(input  logic        keep_valid,
                           input  logic [7:0]  next_data,
                           input  int          inj_cyc,
                           input  logic [7:0]  inj_data,
                           output int          npulse,
                           output int          bad_pos,
                           output int          latch_cyc,
                           output logic [7:0]  latched,
                           output int          ready_cyc,
                           output logic [15:0] stream,
                           output int          viol);
        logic [7:0] sreg;
        sreg      = 8'h00;
        npulse    = 0;
        bad_pos   = 0;
        latch_cyc = -1;
        latched   = 8'h00;
        ready_cyc = -1;
        stream    = 16'h0000;
        viol      = 0;
        @(posedge clk_sr);
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk_sr);
            if (cyc == 0) begin
                if (keep_valid) ld_if.load_data = next_data;
                else            ld_if.load_valid = 1'b0;
            end
            if (cyc == inj_cyc) begin
                ld_if.load_valid = 1'b1;
                ld_if.load_data  = inj_data;
            end
            if (cyc == inj_cyc + 1) ld_if.load_valid = 1'b0;
            if (sr_shift) begin
                npulse++;
                if (cyc != npulse * DIV) bad_pos++;
                stream = {stream[14:0], sr_data};
                sreg   = {sreg[6:0], sr_data};
            end
            if (sr_shift && sr_latch) viol++;
            if (sr_latch) begin
                if (latch_cyc < 0) latch_cyc = cyc;
                else               viol++;
                if (sr_data) viol++;
                latched = sreg;
            end
            if (ld_if.in_ready) begin
                ready_cyc = cyc;
                break;
            end
            if (!busy) viol++;
        end
    endtask

    task automatic check_word(input vec_t v, input int npulse, input int bad_pos,
                              input int latch_cyc, input logic [7:0] latched,
                              input int ready_cyc, input logic [15:0] stream,
                              input int viol);
        check($sformatf("w%02h pulses", v.word), npulse, EXP_PULSES);
        check($sformatf("w%02h pulse_cycles_off", v.word), bad_pos, 0);
        check($sformatf("w%02h latch_cycle", v.word), latch_cyc, EXP_LATCH);
        check($sformatf("w%02h latched_reg", v.word), int'(latched), int'(v.reg_val));
        check($sformatf("w%02h ready_cycle", v.word), ready_cyc, EXP_READY);
        check($sformatf("w%02h serial_stream", v.word), int'(stream), int'(v.stream));
        check($sformatf("w%02h protocol_violations", v.word), viol, 0);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   npulse, bad_pos, latch_cyc, ready_cyc, viol, latch_seen;
        logic [7:0]  latched;
        logic [15:0] stream;

`ifdef SR_PARITY_EN
        // register = {word[6:0], parity}; stream = {word, parity}
        vecs[0] = '{8'hA5, 8'h4A, 16'h014A};
        vecs[1] = '{8'h3C, 8'h78, 16'h0078};
        vecs[2] = '{8'hFF, 8'hFE, 16'h01FE};
        vecs[3] = '{8'hC3, 8'h86, 16'h0186};
        vecs[4] = '{8'h81, 8'h02, 16'h0102};
        vecs[5] = '{8'h07, 8'h0F, 16'h000F};
        vecs[6] = '{8'h00, 8'h00, 16'h0000};
        vecs[7] = '{8'h01, 8'h03, 16'h0003};
`else
        vecs[0] = '{8'hA5, 8'hA5, 16'h00A5};
        vecs[1] = '{8'h3C, 8'h3C, 16'h003C};
        vecs[2] = '{8'hFF, 8'hFF, 16'h00FF};
        vecs[3] = '{8'hC3, 8'hC3, 16'h00C3};
        vecs[4] = '{8'h81, 8'h81, 16'h0081};
        vecs[5] = '{8'h07, 8'h07, 16'h0007};
        vecs[6] = '{8'h00, 8'h00, 16'h0000};
        vecs[7] = '{8'h01, 8'h01, 16'h0001};
`endif

        ld_if.load_valid = 1'b0;
        ld_if.load_data  = 8'h00;

        // Reset held for 3 cycles, then released.
        rst = 1'b0;
        repeat (3) @(negedge clk_sr);
        check("rst in_ready", int'(ld_if.in_ready), 0);
        check("rst sr_data",  int'(sr_data),  0);
        check("rst sr_shift", int'(sr_shift), 0);
        check("rst sr_latch", int'(sr_latch), 0);
        check("rst busy",     int'(busy),     0);
        rst = 1'b1;
        #1;
        check("release in_ready_before_edge", int'(ld_if.in_ready), 0);
        @(negedge clk_sr);
        check("release in_ready_after_edge", int'(ld_if.in_ready), 1);
        check("release busy", int'(busy), 0);

        // Table of single words.
        for (int i = 0; i < 8; i++) begin
            drive_word(vecs[i].word);
            observe(1'b0, 8'h00, -5, 8'h00, npulse, bad_pos, latch_cyc,
                    latched, ready_cyc, stream, viol);
            check_word(vecs[i], npulse, bad_pos, latch_cyc, latched,
                       ready_cyc, stream, viol);
        end

        // Back-to-back: load_valid stays high, 0x3C then 0xFF.
        drive_word(8'h3C);
        observe(1'b1, 8'hFF, -5, 8'h00, npulse, bad_pos, latch_cyc,
                latched, ready_cyc, stream, viol);
        check_word(vecs[1], npulse, bad_pos, latch_cyc, latched,
                   ready_cyc, stream, viol);
        check("b2b valid_held", int'(ld_if.load_valid), 1);
        observe(1'b0, 8'h00, -5, 8'h00, npulse, bad_pos, latch_cyc,
                latched, ready_cyc, stream, viol);
        check_word(vecs[2], npulse, bad_pos, latch_cyc, latched,
                   ready_cyc, stream, viol);

        // load_valid pulsed with 0x00 at cycle 10 of a 0xC3 word.
        drive_word(8'hC3);
        observe(1'b0, 8'h00, 10, 8'h00, npulse, bad_pos, latch_cyc,
                latched, ready_cyc, stream, viol);
        check_word(vecs[3], npulse, bad_pos, latch_cyc, latched,
                   ready_cyc, stream, viol);
        @(negedge clk_sr);
        check("ignored_load not_accepted", int'(busy), 0);

        // Reset asserted at cycle 17 of a word.
        drive_word(8'h5A);
        latch_seen = 0;
        @(posedge clk_sr);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk_sr);
            if (c == 0) ld_if.load_valid = 1'b0;
            if (sr_latch) latch_seen++;
        end
        check("midrst busy_before", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst in_ready", int'(ld_if.in_ready), 0);
        check("midrst sr_data",  int'(sr_data),  0);
        check("midrst sr_shift", int'(sr_shift), 0);
        check("midrst sr_latch", int'(sr_latch), 0);
        check("midrst busy",     int'(busy),     0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_sr);
            if (sr_latch) latch_seen++;
        end
        check("midrst no_latch", latch_seen, 0);
        rst = 1'b1;
        @(negedge clk_sr);
        check("midrst ready_after_release", int'(ld_if.in_ready), 1);
        v = vecs[4];
        drive_word(v.word);
        observe(1'b0, 8'h00, -5, 8'h00, npulse, bad_pos, latch_cyc,
                latched, ready_cyc, stream, viol);
        check_word(v, npulse, bad_pos, latch_cyc, latched,
                   ready_cyc, stream, viol);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
